// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults for the channel FIFO and the glue around it.
// Contents:
//    FIFO_WIDTH      - default data word width in bits
//    FIFO_DEPTH_LOG2 - default log2 of storage depth
//    FIFO_AF_LEVEL   - default occupancy at which almost_full asserts
package fifo_pkg;
   localparam int FIFO_WIDTH      = 8;
   localparam int FIFO_DEPTH_LOG2 = 7;
   localparam int FIFO_AF_LEVEL   = 120;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage for chan_fifo.
// Write is synchronous, read is asynchronous so the head word is presented
// without a pop (first-word-fall-through). Contents are never reset.
// Ports:
//    clk   - write clock
//    we    - write enable
//    waddr - write address
//    wdata - write data
//    raddr - read address
//    rdata - word stored at raddr (combinational)
module fifo_ram #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/chan_fifo.sv
// chan_fifo: single-clock first-word-fall-through channel FIFO.
// Ports:
//    clk_in       - clock, rising edge
//    reset_in     - synchronous active-high reset (pointers, count, flags)
//    din, wr_en   - producer data and write request
//    full         - occupancy == DEPTH
//    almost_full  - occupancy >= AF_LEVEL
//    dout         - head-of-queue word, valid while empty is low
//    rd_en        - consumer pop request
//    empty        - occupancy == 0
//    data_count   - occupancy, 0..DEPTH
//    clr_flags_in - clears the sticky error flags
//    overflow     - sticky: a write was refused
//    underflow    - sticky: a read was refused
//
// Handshake: wr_en is the producer's valid and is accepted on an edge when
// full is low, or when full is high but a pop (rd_en) happens on that same
// edge; rd_en is the consumer's request and is accepted when empty is low.
// A refused request is dropped (never held) and raises the matching sticky
// flag. All status outputs are registers, so none depends on wr_en/rd_en
// within the cycle.
module chan_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH      = FIFO_WIDTH,
   parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
   parameter int AF_LEVEL   = FIFO_AF_LEVEL
) (
   input  logic                  clk_in,
   input  logic                  reset_in,
   input  logic [WIDTH-1:0]      din,
   input  logic                  wr_en,
   output logic                  full,
   output logic                  almost_full,
   output logic [WIDTH-1:0]      dout,
   input  logic                  rd_en,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   data_count,
   input  logic                  clr_flags_in,
   output logic                  overflow,
   output logic                  underflow
);
   localparam int AW = DEPTH_LOG2;
   localparam int CW = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(1 << DEPTH_LOG2);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;
   logic          ovf_evt;
   logic          unf_evt;
   logic [CW-1:0] next_count;

   // A full FIFO can still take a write when the head is popped on the same
   // edge: the freed slot is the one the write pointer targets.
   assign do_rd   = rd_en & ~empty;
   assign do_wr   = wr_en & (~full | rd_en);
   assign ovf_evt = wr_en & full & ~rd_en;
   assign unf_evt = rd_en & empty;

   always_comb begin
      next_count = data_count;
      case ({do_wr, do_rd})
         2'b10:   next_count = data_count + CW'(1);
         2'b01:   next_count = data_count - CW'(1);
         default: next_count = data_count;
      endcase
   end

   // Status flags are computed from next_count so they move on the same
   // edge as the pointers rather than one cycle behind.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         data_count  <= '0;
         empty       <= 1'b1;
         full        <= 1'b0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         data_count  <= next_count;
         empty       <= (next_count == '0);
         full        <= (next_count == DEPTH_C);
         almost_full <= (next_count >= AF_C);
         // A fresh error on the clearing edge wins over the clear.
         overflow    <= ovf_evt | (overflow  & ~clr_flags_in);
         underflow   <= unf_evt | (underflow & ~clr_flags_in);
      end
   end

   fifo_ram #(
      .WIDTH  (WIDTH),
      .ADDR_W (AW)
   ) u_ram (
      .clk   (clk_in),
      .we    (do_wr),
      .waddr (wr_ptr),
      .wdata (din),
      .raddr (rd_ptr),
      .rdata (dout)
   );
endmodule

// File: tb/tb_chan_fifo.sv
// tb_chan_fifo: directed self-checking bench for chan_fifo.
module tb_chan_fifo;
   logic       clk_in = 1'b0;
   logic       reset_in;
   logic [7:0] din;
   logic       wr_en;
   logic       full;
   logic       almost_full;
   logic [7:0] dout;
   logic       rd_en;
   logic       empty;
   logic [7:0] data_count;
   logic       clr_flags_in;
   logic       overflow;
   logic       underflow;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];

   chan_fifo #(.WIDTH(8), .DEPTH_LOG2(7), .AF_LEVEL(120)) dut (
      .clk_in       (clk_in),
      .reset_in     (reset_in),
      .din          (din),
      .wr_en        (wr_en),
      .full         (full),
      .almost_full  (almost_full),
      .dout         (dout),
      .rd_en        (rd_en),
      .empty        (empty),
      .data_count   (data_count),
      .clr_flags_in (clr_flags_in),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // clock / reset
   always #5 clk_in = ~clk_in;

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks: inputs change 1 time unit after the edge, outputs are
   // sampled at the same point (state after the edge just taken)
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; rd_en = 1'b0; clr_flags_in = 1'b0; reset_in = 1'b0;
   endtask

   task automatic push(input logic [7:0] v);
      din = v; wr_en = 1'b1; rd_en = 1'b0;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1; wr_en = 1'b0;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic check_flags_clear(input string tag);
      check({tag, "_ovf"}, 32'(overflow), 32'd0);
      check({tag, "_unf"}, 32'(underflow), 32'd0);
   endtask

   initial begin
      din = 8'h00;
      idle();
      #1;
      // reset
      reset_in = 1'b1;
      tick();
      reset_in = 1'b0;
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_af", 32'(almost_full), 32'd0);
      check("rst_count", 32'(data_count), 32'd0);
      check_flags_clear("rst");

      // three words in, three out
      push(8'h11);
      check("fwft_dout", 32'(dout), 32'h11);
      check("fwft_empty", 32'(empty), 32'd0);
      check("fwft_count", 32'(data_count), 32'd1);
      push(8'h22);
      push(8'h33);
      check("three_count", 32'(data_count), 32'd3);
      check("three_dout", 32'(dout), 32'h11);
      check("three_rd0", 32'(dout), 32'h11); pop();
      check("three_rd1", 32'(dout), 32'h22); pop();
      check("three_rd2", 32'(dout), 32'h33); pop();
      check("three_empty", 32'(empty), 32'd1);
      check("three_count0", 32'(data_count), 32'd0);

      // fill to DEPTH, watching almost_full and full thresholds
      for (int i = 0; i < 128; i++) begin
         push(8'(i));
         check("fill_count", 32'(data_count), 32'(i + 1));
         check("fill_af", 32'(almost_full), 32'((i + 1) >= 120));
         check("fill_full", 32'(full), 32'((i + 1) == 128));
      end
      check("fill_ovf0", 32'(overflow), 32'd0);
      push(8'hFF);
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_count", 32'(data_count), 32'd128);
      check("ovf_full", 32'(full), 32'd1);
      check("ovf_head", 32'(dout), 32'h00);
      clr_flags_in = 1'b1;
      tick();
      clr_flags_in = 1'b0;
      check("ovf_clr", 32'(overflow), 32'd0);

      // full FIFO: simultaneous write and read both accepted
      din = 8'hAA; wr_en = 1'b1; rd_en = 1'b1;
      tick();
      idle();
      check("fullrw_count", 32'(data_count), 32'd128);
      check("fullrw_full", 32'(full), 32'd1);
      check("fullrw_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 128; i++) begin
         check("drain_dout", 32'(dout), (i < 127) ? 32'(i + 1) : 32'hAA);
         pop();
         check("drain_count", 32'(data_count), 32'(127 - i));
         check("drain_af", 32'(almost_full), 32'((127 - i) >= 120));
      end
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_unf", 32'(underflow), 32'd0);

      // empty FIFO: read refused, same-cycle write accepted
      din = 8'h5C; wr_en = 1'b1; rd_en = 1'b1;
      tick();
      idle();
      check("unf_set", 32'(underflow), 32'd1);
      check("unf_count", 32'(data_count), 32'd1);
      check("unf_dout", 32'(dout), 32'h5C);
      check("unf_empty", 32'(empty), 32'd0);
      clr_flags_in = 1'b1;
      tick();
      clr_flags_in = 1'b0;
      check("unf_clr", 32'(underflow), 32'd0);
      pop();
      check("unf_drained", 32'(empty), 32'd1);
      // clear and a new error on the same edge: error wins
      clr_flags_in = 1'b1; rd_en = 1'b1;
      tick();
      idle();
      check("clr_prio", 32'(underflow), 32'd1);
      clr_flags_in = 1'b1;
      tick();
      clr_flags_in = 1'b0;
      check("clr_after", 32'(underflow), 32'd0);

      // pointer wrap: hold occupancy at 5 across 200 write/read pairs
      for (int k = 0; k < 5; k++) begin
         push(8'(k + 8'h40));
         exp_q.push_back(8'(k + 8'h40));
      end
      for (int k = 0; k < 200; k++) begin
         din = 8'(k * 3 + 7); wr_en = 1'b1; rd_en = 1'b1;
         exp_q.push_back(8'(k * 3 + 7));
         check("wrap_dout", 32'(dout), 32'(exp_q.pop_front()));
         tick();
         check("wrap_count", 32'(data_count), 32'd5);
      end
      idle();
      check_flags_clear("wrap");
      check("wrap_full", 32'(full), 32'd0);
      while (exp_q.size() > 0) begin
         check("wrap_tail", 32'(dout), 32'(exp_q.pop_front()));
         pop();
      end
      check("wrap_empty", 32'(empty), 32'd1);

      // reset mid-traffic overrides concurrent requests
      for (int i = 0; i < 50; i++) push(8'(8'hC0 + i));
      check("load50_count", 32'(data_count), 32'd50);
      din = 8'h77; wr_en = 1'b1; rd_en = 1'b1; reset_in = 1'b1;
      tick();
      idle();
      check("mid_rst_count", 32'(data_count), 32'd0);
      check("mid_rst_empty", 32'(empty), 32'd1);
      check("mid_rst_full", 32'(full), 32'd0);
      check("mid_rst_af", 32'(almost_full), 32'd0);
      check_flags_clear("mid_rst");
      push(8'h9E);
      check("post_rst_dout", 32'(dout), 32'h9E);
      check("post_rst_count", 32'(data_count), 32'd1);
      check("post_rst_empty", 32'(empty), 32'd0);

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/chan_fifo.md
CHAN_FIFO -- requirements
Module: chan_fifo

Interface
REQ-001 Parameter: WIDTH, 8, data word width in bits.
REQ-002 Parameter: DEPTH_LOG2, 7, log2 of storage depth (DEPTH = 2**DEPTH_LOG2 = 128).
REQ-003 Parameter: AF_LEVEL, 120, occupancy at or above which almost_full asserts.
REQ-004 Port: clk_in  input  1  single clock; all logic on rising edge.
REQ-005 Port: reset_in  input  1  reset; synchronous and active-high.
REQ-006 Port: din  input  WIDTH  producer data (fed from chanDataOut or a local producer).
REQ-007 Port: wr_en  input  1  producer write request.
REQ-008 Port: full  output  1  high when occupancy == DEPTH.
REQ-009 Port: almost_full  output  1  high when occupancy >= AF_LEVEL.
REQ-010 Port: dout  output  WIDTH  head-of-queue word, valid whenever empty is low.
REQ-011 Port: rd_en  input  1  consumer pop request (driven from chanRead qualified by channel address).
REQ-012 Port: empty  output  1  high when occupancy == 0.
REQ-013 Port: data_count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
REQ-014 Port: clr_flags_in  input  1  clears sticky error flags.
REQ-015 Port: overflow  output  1  sticky; a write was refused.
REQ-016 Port: underflow  output  1  sticky; a read was refused.

Function
REQ-017 Storage SHALL be DEPTH words; write and read pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
REQ-018 Output SHALL be first-word-fall-through: dout equals the oldest stored word with no rd_en needed to present it.
REQ-019 A write accepted on edge N SHALL make empty low and the word visible on dout after edge N (zero extra latency) when the FIFO was empty.
REQ-020 rd_en with empty low SHALL pop the head on that edge; the next word appears on dout after the same edge.
REQ-021 wr_en with full low SHALL store din and advance the write pointer.
REQ-022 wr_en with full high and rd_en low SHALL be ignored and SHALL set overflow.
REQ-023 wr_en and rd_en together with full high SHALL both be accepted; data_count stays DEPTH, full stays high.
REQ-024 rd_en with empty high SHALL be ignored and SHALL set underflow, including when wr_en is simultaneously high (the write is accepted, count becomes 1).
REQ-025 Simultaneous accepted read and write SHALL leave data_count unchanged.
REQ-026 data_count, full, empty, almost_full SHALL be registered and updated on the same edge as the pointers, never lagging by a cycle.
REQ-027 clr_flags_in SHALL clear overflow and underflow on the next edge; a new error on that same edge takes priority (flag stays set).
REQ-028 No output SHALL be combinationally dependent on wr_en or rd_en.

Reset
REQ-029 reset_in high at an edge SHALL set both pointers to 0, data_count 0, empty 1, full 0, almost_full 0, overflow 0, underflow 0; it overrides all concurrent wr_en/rd_en.
REQ-030 Storage contents SHALL NOT be cleared by reset; dout is don't-care while empty is high.
REQ-031 Reset asserted mid-traffic SHALL discard all queued words; first write after reset reappears at dout unaffected by prior contents.

Structure
REQ-032 Shared package fifo_pkg SHALL hold default WIDTH, DEPTH_LOG2, AF_LEVEL constants for reuse by channel-level glue.
REQ-033 Storage SHALL be one sub-module, fifo_ram: simple dual-port, synchronous write, asynchronous read at the read pointer.
REQ-034 Pointer, count and flag logic SHALL live in chan_fifo; target 150-300 lines total.

Verification
REQ-035 After reset, write 0x11,0x22,0x33 on consecutive cycles -> dout 0x11 one edge after first write, empty 0, data_count 3; three reads yield 0x11,0x22,0x33, then empty 1, data_count 0.
REQ-036 Write 128 words 0x00..0x7F -> almost_full rises at count 120, full at 128; 129th write ignored, overflow 1, data_count 128, read-back order 0x00..0x7F intact.
REQ-037 Full FIFO, assert wr_en(0xAA) and rd_en together -> data_count stays 128, full stays 1, overflow 0, 0xAA emerges as 128th subsequent read.
REQ-038 Empty FIFO, rd_en with wr_en(0x5C) together -> underflow 1, data_count 1, dout 0x5C; pulse clr_flags_in -> underflow 0 next edge.
REQ-039 Pointer wrap: 200 interleaved write/read pairs with count held at 5 -> data in order, no flags set.
REQ-040 Load 50 words, assert reset_in one cycle with wr_en/rd_en high -> data_count 0, empty 1, flags 0; next write 0x9E appears on dout.
